// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the instruction-memory boot loader.
//   - loader_state_t : loader FSM state encoding
//   - WORD_BYTES     : bytes packed into one instruction word
//   - LOADER_LEN_W   : width of the frame length (word count) field
// Optional feature macro: IMEM_LOADER_CSUM_EN adds the S_CSUM state.
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int WORD_BYTES   = 4;
    localparam int LOADER_LEN_W = 16;

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
`ifdef IMEM_LOADER_CSUM_EN
        S_CSUM,
`endif
        S_RUN,
        S_ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Boot-time program loader. Receives a framed byte stream
// (LEN_LO, LEN_HI, 4*N data bytes [, checksum]) and writes little-endian
// packed 32-bit words to instruction memory at word addresses 0..N-1 while
// holding the core in reset. Releases the core once the frame completes.
//
// Optional feature macro: IMEM_LOADER_CSUM_EN
//   When defined, a trailing checksum byte is required: the mod-256 sum of
//   all data bytes plus the checksum byte must equal 8'h00.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   s_valid    in   byte stream valid
//   s_data     in   byte stream data [7:0]
//   s_ready    out  loader can accept a byte
//   imem_we    out  instruction-memory write strobe (one cycle per word)
//   imem_addr  out  word address of the write [ADDR_W-1:0]
//   imem_wdata out  word to write [31:0]
//   cpu_rst    out  active-high reset to the pipeline
//   done       out  program loaded, core running
//   err        out  frame rejected, core held in reset
// ---------------------------------------------------------------------------
module imem_loader
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam int BUF_W = 8 * (WORD_BYTES - 1);

    // Memory capacity in words; one bit wider than the length field so that
    // a full 2^16-word memory is still representable.
    localparam logic [LOADER_LEN_W:0] MAX_WORDS = (LOADER_LEN_W + 1)'(1) << ADDR_W;

    loader_state_t            state_q, state_d;
    logic [1:0]               byte_cnt_q, byte_cnt_d;
    logic [LOADER_LEN_W-1:0]  word_cnt_q, word_cnt_d;
    logic [LOADER_LEN_W-1:0]  len_q, len_d;
    logic [BUF_W-1:0]         word_buf_q, word_buf_d;
    logic                     imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]        imem_addr_q, imem_addr_d;
    logic [31:0]              imem_wdata_q, imem_wdata_d;

    logic                     accept;
    logic                     data_accept;
    logic [LOADER_LEN_W-1:0]  n_words;

`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]               sum_q, sum_d;
    logic [7:0]               csum_total;

    assign sum_d      = data_accept ? sum_q + s_data : sum_q;
    assign csum_total = sum_q + s_data;
`endif

    assign accept  = s_valid & s_ready;
    assign n_words = {s_data, len_q[7:0]};

    // Lanes 0..2 are buffered; lane 3 is taken straight from s_data when the
    // word is emitted, so the full word is ready the cycle its last byte lands.
    generate
        for (genvar gi = 0; gi < WORD_BYTES - 1; gi++) begin : g_lane
            assign word_buf_d[8*gi +: 8] =
                (data_accept && (byte_cnt_q == 2'(gi))) ? s_data : word_buf_q[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        len_d        = len_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        data_accept  = 1'b0;

        unique case (state_q)
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = s_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = s_data;
                    if ({1'b0, n_words} > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else if (n_words == '0) begin
`ifdef IMEM_LOADER_CSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_RUN;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
`ifndef IMEM_LOADER_CSUM_EN
                // All words queued: this is the cycle the last strobe is on
                // the bus, so the core is released on the next one. Any byte
                // offered now lies beyond the frame and is dropped.
                if (word_cnt_q == len_q) begin
                    state_d = S_RUN;
                end else
`endif
                if (accept) begin
                    data_accept = 1'b1;
                    byte_cnt_d  = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'(WORD_BYTES - 1)) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_cnt_q[ADDR_W-1:0];
                        imem_wdata_d = {s_data, word_buf_q};
                        word_cnt_d   = word_cnt_q + LOADER_LEN_W'(1);
`ifdef IMEM_LOADER_CSUM_EN
                        if ((word_cnt_q + LOADER_LEN_W'(1)) == len_q) begin
                            state_d = S_CSUM;
                        end
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_d = (csum_total == 8'h00) ? S_RUN : S_ERR;
                end
            end
`endif
            S_RUN: begin
                state_d = S_RUN;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LEN_LO;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            len_q        <= '0;
            word_buf_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            len_q        <= len_d;
            word_buf_q   <= word_buf_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
`ifdef IMEM_LOADER_CSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;

    assign s_ready = (state_q != S_RUN) && (state_q != S_ERR);
    assign cpu_rst = (state_q != S_RUN);
    assign done    = (state_q == S_RUN);
    assign err     = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
// Directed + randomized bench for imem_loader. Frames are built from word
// lists; the expected write sequence is simply "word i lands at address i",
// and expected release timing is derived from the byte accept cycles.
// Honours IMEM_LOADER_CSUM_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              s_valid = 1'b0;
    logic [7:0]        s_data = 8'h00;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed write log and release cycle, sampled mid-cycle.
    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          rel_cyc = -1;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(int'(imem_addr));
            wr_data.push_back(imem_wdata);
            wr_cyc.push_back(cyc);
        end
        if (cpu_rst === 1'b0 && rel_cyc < 0) rel_cyc = cyc;
    end

    // Frame under test and the stimulus-side timing record.
    logic [31:0] frame_words[$];
    int          acc4_cyc[$];
    int          lenhi_cyc;
    int          last_acc_cyc;
    int          csum_cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    // Present one byte; returns the cycle in which the handshake completes.
    task automatic send_byte(input logic [7:0] b, output int acc);
        int waited;
        waited = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        while (s_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (s_ready !== 1'b1) chk("ready_timeout", {31'b0, s_ready}, 32'd1);
        acc = cyc;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        acc4_cyc.delete();
        rel_cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        clear_log();
    endtask

    // Sends LEN + all of frame_words (+ checksum when enabled).
    task automatic send_frame(input int len_field, input int gap_at, input int gap_len,
                              input bit rand_gaps, input bit bad_csum);
        int          c;
        int          idx;
        logic [7:0]  b;
        logic [7:0]  sum;
        logic [15:0] lf;
        lf  = 16'(len_field);
        sum = 8'h00;
        idx = 0;
        send_byte(lf[7:0], c);
        send_byte(lf[15:8], lenhi_cyc);
        for (int w = 0; w < frame_words.size(); w++) begin
            for (int j = 0; j < 4; j++) begin
                b = 8'(frame_words[w] >> (8 * j));
                if (idx == gap_at) idle(gap_len);
                if (rand_gaps) idle(int'($urandom_range(0, 2)));
                send_byte(b, c);
                sum = sum + b;
                if (j == 3) acc4_cyc.push_back(c);
                last_acc_cyc = c;
                idx++;
            end
        end
`ifdef IMEM_LOADER_CSUM_EN
        if (len_field <= (1 << ADDR_W)) begin
            b = 8'h00 - sum;
            if (bad_csum) b = b - 8'h01;
            send_byte(b, csum_cyc);
        end
`else
        if (bad_csum) csum_cyc = -1;
`endif
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Writes must be word i at address i, one cycle after its 4th byte.
    task automatic check_writes(input string tag, input int n);
        chk({tag, "_nwr"}, wr_addr.size(), n);
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            chk({tag, "_addr"}, wr_addr[i], i);
            chk({tag, "_data"}, wr_data[i], frame_words[i]);
            chk({tag, "_wcyc"}, wr_cyc[i], acc4_cyc[i] + 1);
        end
    endtask

    task automatic check_load(input string tag, input int n);
        int exp_rel;
        repeat (4) @(negedge clk);
        check_writes(tag, n);
`ifdef IMEM_LOADER_CSUM_EN
        exp_rel = csum_cyc + 1;
`else
        exp_rel = (n == 0) ? lenhi_cyc + 1 : last_acc_cyc + 2;
`endif
        chk({tag, "_rel"}, rel_cyc, exp_rel);
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_err"}, {31'b0, err}, 32'd0);
        chk({tag, "_cpurst"}, {31'b0, cpu_rst}, 32'd0);
        chk({tag, "_ready"}, {31'b0, s_ready}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'b0, s_ready}, 32'd1);
        chk("rst_we", {31'b0, imem_we}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_cpurst", {31'b0, cpu_rst}, 32'd1);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        clear_log();

        // Basic load
        frame_words = '{32'h00500293, 32'h00000063};
        send_frame(2, -1, 0, 1'b0, 1'b0);
        check_load("basic", 2);
        $display("txn basic: N=2 writes=%0d rel_cyc=%0d", wr_addr.size(), rel_cyc);

        // Backpressure: 3 idle cycles between bytes 2 and 3 of word 0
        do_reset();
        send_frame(2, 2, 3, 1'b0, 1'b0);
        check_load("bp", 2);
        $display("txn backpressure: N=2 writes=%0d rel_cyc=%0d", wr_addr.size(), rel_cyc);

        // Oversize frame
        do_reset();
        frame_words.delete();
        send_frame(257, -1, 0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("ovr_err", {31'b0, err}, 32'd1);
        chk("ovr_ready", {31'b0, s_ready}, 32'd0);
        chk("ovr_cpurst", {31'b0, cpu_rst}, 32'd1);
        chk("ovr_done", {31'b0, done}, 32'd0);
        chk("ovr_nwr", wr_addr.size(), 0);
        $display("txn oversize: N=257 err=%0b writes=%0d", err, wr_addr.size());

        // Mid-frame reset after 6 data bytes of an N=2 frame
        do_reset();
        frame_words = '{$urandom, $urandom};
        begin
            logic [15:0] lf;
            logic [7:0]  b;
            lf = 16'd2;
            send_byte(lf[7:0], c);
            send_byte(lf[15:8], c);
            for (int k = 0; k < 6; k++) begin
                b = 8'(frame_words[k / 4] >> (8 * (k % 4)));
                send_byte(b, c);
                if (k == 3) acc4_cyc.push_back(c);
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_writes("midrst", 1);
        chk("midrst_cpurst", {31'b0, cpu_rst}, 32'd1);
        chk("midrst_ready", {31'b0, s_ready}, 32'd1);
        chk("midrst_rel", rel_cyc, 32'hffff_ffff);
        $display("txn midreset: writes=%0d cpu_rst=%0b", wr_addr.size(), cpu_rst);
        clear_log();
        frame_words = '{$urandom};
        send_frame(1, -1, 0, 1'b0, 1'b0);
        check_load("postrst", 1);
        $display("txn post-reset: N=1 data=%08h", frame_words[0]);

        // Empty frame
        do_reset();
        frame_words.delete();
        send_frame(0, -1, 0, 1'b0, 1'b0);
        check_load("empty", 0);
        $display("txn empty: N=0 writes=%0d rel_cyc=%0d lenhi=%0d", wr_addr.size(), rel_cyc, lenhi_cyc);

        // Randomized frames with random stall gaps
        for (int t = 0; t < 6; t++) begin
            do_reset();
            n = int'($urandom_range(1, 12));
            frame_words.delete();
            for (int i = 0; i < n; i++) frame_words.push_back($urandom);
            send_frame(n, -1, 0, 1'b1, 1'b0);
            check_load("rand", n);
            $display("txn random %0d: N=%0d writes=%0d rel_cyc=%0d", t, n, wr_addr.size(), rel_cyc);
        end

        // Boundary: N == 2^ADDR_W fills memory exactly
        do_reset();
        frame_words.delete();
        for (int i = 0; i < (1 << ADDR_W); i++) frame_words.push_back($urandom);
        send_frame(1 << ADDR_W, -1, 0, 1'b0, 1'b0);
        check_load("full", 1 << ADDR_W);
        $display("txn full: N=%0d writes=%0d", 1 << ADDR_W, wr_addr.size());

`ifdef IMEM_LOADER_CSUM_EN
        // Checksum good (01 02 03 04 + F6) and bad (F5)
        do_reset();
        frame_words = '{32'h04030201};
        send_frame(1, -1, 0, 1'b0, 1'b0);
        check_load("csum_ok", 1);
        $display("txn csum good: done=%0b", done);
        do_reset();
        send_frame(1, -1, 0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        chk("csum_bad_err", {31'b0, err}, 32'd1);
        chk("csum_bad_cpurst", {31'b0, cpu_rst}, 32'd1);
        chk("csum_bad_done", {31'b0, done}, 32'd0);
        $display("txn csum bad: err=%0b", err);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader on the instruction-memory write port of `riscv_pipeline`. It accepts a framed byte stream over a valid/ready handshake and packs little-endian bytes into 32-bit words. It writes each word to consecutive instruction-memory addresses from 0, holding the core in reset throughout. When the frame completes, it releases the core reset so fetch starts at PC 0 with the new program; the core drives no bus back to the loader.

## Interface
- `ADDR_W`, 8, word-address width of instruction memory (capacity 2^ADDR_W words)
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `s_valid`  in  1  byte stream valid
- `s_data`  in  8  byte stream data
- `s_ready`  out  1  loader can accept a byte
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word
- `imem_addr`  out  ADDR_W  word address of the write
- `imem_wdata`  out  32  word to write
- `cpu_rst`  out  1  reset to the pipeline, active-high
- `done`  out  1  program loaded, core running
- `err`  out  1  frame rejected, core held in reset

## Operation
- Frame format: `LEN_LO`, `LEN_HI` (N = word count, 16-bit little-endian), then 4N data bytes (byte 0 → bits 7:0), then optional checksum byte (see Configuration).
- A byte is accepted on a cycle with `s_valid & s_ready`.
- FSM states: `S_LEN_LO`, `S_LEN_HI`, `S_DATA`, `S_CSUM` (macro only), `S_RUN`, `S_ERR`.
- Transitions:
  - `S_LEN_LO` → `S_LEN_HI` on accept.
  - `S_LEN_HI` → on accept, based on N:
    - N > 2^ADDR_W → `S_ERR`.
    - N == 0 → `S_CSUM`/`S_RUN`.
    - otherwise → `S_DATA`.
  - `S_DATA` → after accepting the final (4N-th) byte, go to `S_CSUM`, or to `S_RUN` once the last write has issued.
  - `S_RUN` and `S_ERR` are terminal until `rst`.
- `s_ready` = 1 in `S_LEN_LO`, `S_LEN_HI`, `S_DATA`, `S_CSUM`; 0 in `S_RUN`, `S_ERR`.
- Byte counter (2 bits) selects the lane. Word counter (16 bits) counts words written.
- `imem_addr` = word counter truncated to ADDR_W bits. It increments after each write. N == 2^ADDR_W fills memory exactly; no wrap occurs.
- `cpu_rst` = 1 in every state except `S_RUN`. `done` = 1 only in `S_RUN`. `err` = 1 only in `S_ERR`.
- Instruction-memory contents are never cleared by the loader.

## Timing
- Reset values:
  - `s_ready`=1, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_rst`=1, `done`=0, `err`=0
  - state `S_LEN_LO`, all counters 0.
- Write latency: `imem_we`, `imem_addr` and `imem_wdata` are registered. The strobe is high for exactly the cycle after the 4th byte of a word is accepted.
- Throughput: one byte per cycle sustained; `s_ready` never drops inside `S_DATA`.
- Release: `cpu_rst` falls, and `done` rises, on the cycle after the last word's `imem_we` cycle. The last word is therefore in memory before the core leaves reset.
- N == 0 (no macro): `cpu_rst` falls the cycle after `LEN_HI` is accepted.
- `s_valid` low mid-word: byte lane and partial word are held, with no timeout.
- `rst` mid-frame: returns to reset state next edge. The partial word is discarded and not written; `cpu_rst` returns to 1.
- `rst` while in `S_RUN`: core re-held and loader awaits a new frame.

## Configuration
- Macro `IMEM_LOADER_CSUM_EN`.
- Defined:
  - An 8-bit running sum (mod 256) of all data bytes is kept; length bytes are excluded.
  - After the data, `S_CSUM` accepts one byte. Data sum + checksum byte == 8'h00 → `S_RUN`; otherwise `S_ERR`.
  - Release timing is measured from the checksum accept: `cpu_rst` falls the cycle after it.
  - N == 0 still requires the checksum byte, which must be 8'h00.
- Undefined: no `S_CSUM` state and no sum register; the frame ends at the last data byte.

## Structure
- Shared package `riscv_pkg`: FSM state enum `loader_state_t`, byte-count constant `WORD_BYTES`=4, frame-length width `LOADER_LEN_W`=16.
- Single module with no sub-modules. Byte packing is inline shift/lane-select logic.
- Top-level `riscv_pipeline` ORs `cpu_rst` into the pipeline reset. It muxes the loader write port onto instruction memory while `cpu_rst`=1.

## Test plan
- **Basic load:** frame N=2, words 32'h00500293, 32'h00000063 →
  - `imem_we` at addr 0 then addr 1 with those values;
  - `cpu_rst` falls one cycle after the second write; `done`=1.
- **Backpressure gaps:** same frame with `s_valid` low for 3 cycles between bytes 2 and 3 of word 0 → identical writes; no write while stalled.
- **Oversize frame:** ADDR_W=8, N=257 → `S_ERR` after `LEN_HI`; `s_ready`=0, `err`=1, `cpu_rst`=1, zero writes.
- **Mid-frame reset:** `rst` after 6 data bytes of an N=2 frame →
  - only word 0 written;
  - after reset, a fresh N=1 frame writes addr 0 and releases the core.
- **Checksum (macro on):**
  - N=1, bytes 01 02 03 04, checksum 8'hF6 → `done`=1;
  - same frame with checksum 8'hF5 → `err`=1, `cpu_rst` stays 1.
- **Empty frame:** N=0 (macro off) → no writes; `cpu_rst` falls the cycle after `LEN_HI` is accepted.
